// File: rtl/a2d_sweep.sv
// ---------------------------------------------------------------------------
// a2d_sweep
//   SPI master plus channel sequencer for the ADC128S 12-bit A2D.
//   Each nxt pulse runs one sweep over ch0 (lft_ld), ch4 (rght_ld) and
//   ch5 (batt). Every channel takes two 16-bit mode-0 frames. The A2D
//   answers with data for the channel named in the previous frame, so the
//   result comes back in the second frame.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   nxt         single-clk pulse that starts a sweep (ignored while busy)
//   MISO        serial data from the A2D
//   SS_n        active-low slave select
//   SCLK        serial clock, idles high
//   MOSI        serial command data to the A2D
//   lft_ld      latest channel-0 result
//   rght_ld     latest channel-4 result
//   batt        latest channel-5 result
//   busy        high from the clk after an accepted nxt until sweep_done
//   sweep_done  one-clk pulse once all three results are updated
// ---------------------------------------------------------------------------
module a2d_sweep #(
  parameter int DIV_BITS = 5,
  parameter int GAP_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        busy,
  output logic        sweep_done
);

  localparam logic [DIV_BITS-1:0] DIV_ONE  = {{(DIV_BITS-1){1'b0}}, 1'b1};
  localparam logic [DIV_BITS-1:0] DIV_FULL = {DIV_BITS{1'b1}};
  // Half-full minus one: the clk before SCLK rises.
  localparam logic [DIV_BITS-1:0] DIV_SMPL = {1'b0, {(DIV_BITS-1){1'b1}}};
  // All ones with bit DIV_BITS-2 cleared gives the front porch before the
  // first SCLK fall.
  localparam logic [DIV_BITS-1:0] DIV_INIT = DIV_FULL & ~(DIV_ONE << (DIV_BITS-2));

  localparam int               GAP_W    = $clog2(GAP_CLKS) + 1;
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_GAP1 = 3'd2,
    S_READ = 3'd3,
    S_GAP2 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Sweep position 0/1/2 maps onto A2D channels 0/4/5.
  function automatic logic [2:0] chan_code(input logic [1:0] idx);
    logic [2:0] code;
    case (idx)
      2'd0:    code = 3'd0;
      2'd1:    code = 3'd4;
      2'd2:    code = 3'd5;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_BITS-1:0] r_div;
  logic                r_ss_n;
  logic [4:0]          r_bit_cnt;
  logic [15:0]         r_tx;
  logic [11:0]         r_rx;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [1:0]          r_ptr;
  logic [1:0]          w_ptr_nxt;
  logic [11:0]         r_lft;
  logic [11:0]         r_rght;
  logic [11:0]         r_batt;
  logic                r_busy;
  logic                r_sweep_done;

  logic                w_frm_start;
  logic                w_gap_start;
  logic                w_wr_res;
  logic                w_smpl;
  logic                w_shift;
  logic                w_frm_done;
  logic                w_gap_done;
  logic [15:0]         w_cmd;

  assign w_smpl     = ~r_ss_n & (r_div == DIV_SMPL);
  // No shift at the front-porch fall (count 0) nor after the 16th sample,
  // so MOSI presents bit 15 at the first rise and never sees a 17th fall.
  assign w_shift    = ~r_ss_n & (r_div == DIV_FULL) &
                      (r_bit_cnt != 5'd0) & (r_bit_cnt != 5'd16);
  // Frame ends with SCLK still high, one clk before it would fall again.
  assign w_frm_done = ~r_ss_n & (r_div == DIV_FULL) & (r_bit_cnt == 5'd16);
  assign w_gap_done = (r_gap_cnt == GAP_LAST);
  assign w_cmd      = {2'b00, chan_code(w_ptr_nxt), 11'h000};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_frm_start = 1'b0;
    w_gap_start = 1'b0;
    w_wr_res    = 1'b0;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (nxt) begin
          w_state_nxt = S_CMD;
          w_frm_start = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CMD: begin
        if (w_frm_done) begin
          w_state_nxt = S_GAP1;
          w_gap_start = 1'b1;
        end else begin
          w_state_nxt = S_CMD;
        end
      end
      S_GAP1: begin
        if (w_gap_done) begin
          w_state_nxt = S_READ;
          w_frm_start = 1'b1;
        end else begin
          w_state_nxt = S_GAP1;
        end
      end
      S_READ: begin
        if (w_frm_done) begin
          w_state_nxt = S_GAP2;
          w_gap_start = 1'b1;
          w_wr_res    = 1'b1;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_GAP2: begin
        if (w_gap_done) begin
          if (r_ptr == 2'd2) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CMD;
            w_frm_start = 1'b1;
            w_ptr_nxt   = r_ptr + 2'd1;
          end
        end else begin
          w_state_nxt = S_GAP2;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = 2'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = 2'd0;
      end
    endcase
  end

  // SPI engine: divider, slave select, bit counter, shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= DIV_INIT;
      r_ss_n    <= 1'b1;
      r_bit_cnt <= 5'd0;
      r_tx      <= 16'h0000;
      r_rx      <= 12'h000;
    end else if (w_frm_start) begin
      r_div     <= DIV_INIT;
      r_ss_n    <= 1'b0;
      r_bit_cnt <= 5'd0;
      r_tx      <= w_cmd;
      r_rx      <= 12'h000;
    end else if (w_gap_start) begin
      r_div     <= DIV_INIT;
      r_ss_n    <= 1'b1;
      r_bit_cnt <= r_bit_cnt;
      r_tx      <= r_tx;
      r_rx      <= r_rx;
    end else begin
      r_div  <= r_ss_n ? r_div : (r_div + DIV_ONE);
      r_ss_n <= r_ss_n;
      if (w_smpl) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        // Only 12 bits are kept; the four leading bits fall off the top.
        r_rx      <= {r_rx[10:0], MISO};
      end else begin
        r_bit_cnt <= r_bit_cnt;
        r_rx      <= r_rx;
      end
      if (w_shift) begin
        r_tx <= {r_tx[14:0], 1'b0};
      end else begin
        r_tx <= r_tx;
      end
    end
  end

  // Inter-frame gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= {GAP_W{1'b0}};
    end else if (w_gap_start) begin
      r_gap_cnt <= {GAP_W{1'b0}};
    end else if ((r_state == S_GAP1) || (r_state == S_GAP2)) begin
      r_gap_cnt <= r_gap_cnt + GAP_ONE;
    end else begin
      r_gap_cnt <= r_gap_cnt;
    end
  end

  // Result registers: written only as their own second frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lft  <= 12'h000;
      r_rght <= 12'h000;
      r_batt <= 12'h000;
    end else if (w_wr_res) begin
      case (r_ptr)
        2'd0:    r_lft  <= r_rx;
        2'd1:    r_rght <= r_rx;
        2'd2:    r_batt <= r_rx;
        default: r_lft  <= r_lft;
      endcase
    end else begin
      r_lft  <= r_lft;
      r_rght <= r_rght;
      r_batt <= r_batt;
    end
  end

  // Sweep pointer and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= 2'd0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_sweep_done <= (w_state_nxt == S_DONE);
    end
  end

  assign SS_n       = r_ss_n;
  assign SCLK       = r_div[DIV_BITS-1];
  assign MOSI       = r_tx[15];
  assign lft_ld     = r_lft;
  assign rght_ld    = r_rght;
  assign batt       = r_batt;
  assign busy       = r_busy;
  assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_a2d_sweep.sv
// ---------------------------------------------------------------------------
// tb_a2d_sweep
//   Directed bench for a2d_sweep with a small ADC128S behavioural model.
//   A clk-edge monitor measures SS_n low time, SCLK rises, SCLK period and
//   inter-frame gaps; the model records each received MOSI command.
// ---------------------------------------------------------------------------
module tb_a2d_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        MISO = 1'b0;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        busy;
  logic        sweep_done;

  a2d_sweep #(.DIV_BITS(5), .GAP_CLKS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .nxt        (nxt),
    .MISO       (MISO),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .lft_ld     (lft_ld),
    .rght_ld    (rght_ld),
    .batt       (batt),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  initial forever #5 clk = ~clk;

  // ----------------------------------------------------------------- checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ----------------------------------------------------------------- A2D model
  logic [11:0] lft_val;
  logic [11:0] rght_val;
  logic [11:0] batt_val;
  logic [3:0]  up_nib = 4'h0;
  logic [2:0]  prev_ch = 3'd0;
  logic [15:0] m_tx;
  logic [15:0] m_rx;
  int          m_fall = 0;
  int          m_n = 0;
  logic [15:0] m_cmds [64];

  function automatic logic [11:0] val_of(input logic [2:0] ch);
    case (ch)
      3'd0:    return lft_val;
      3'd4:    return rght_val;
      3'd5:    return batt_val;
      default: return 12'h000;
    endcase
  endfunction

  // Data out: load on SS_n fall, shift on every SCLK fall but the first.
  initial forever begin
    @(negedge SS_n or negedge SCLK);
    if (SCLK === 1'b1) begin
      m_fall = 0;
      m_tx   = {up_nib, val_of(prev_ch)};
      MISO   = m_tx[15];
    end else if (SS_n === 1'b0) begin
      m_fall++;
      if (m_fall > 1) begin
        m_tx = {m_tx[14:0], 1'b0};
        MISO = m_tx[15];
      end
    end
  end

  // Command in: capture MOSI on SCLK rise, latch channel on SS_n rise.
  initial forever begin
    @(posedge SCLK or posedge SS_n);
    if (SS_n === 1'b0) begin
      m_rx = {m_rx[14:0], MOSI};
    end else begin
      if (m_n < 64) m_cmds[m_n] = m_rx;
      m_n++;
      prev_ch = m_rx[13:11];
    end
  end

  // ----------------------------------------------------------------- monitor
  int nl = 0;
  int lows [64];
  int rises [64];
  int pers [64];
  int gaps [64];
  int low_cnt = 0;
  int rise_idx = 0;
  int gap_cnt = 0;
  int t1 = 0;
  int t2 = 0;
  int cyc = 0;
  int n_done = 0;
  logic prev_ss = 1'b1;
  logic prev_sclk = 1'b1;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (SS_n === 1'b0) begin
      if (prev_ss) begin
        if (nl < 64) gaps[nl] = gap_cnt;
        low_cnt  = 0;
        rise_idx = 0;
      end
      low_cnt++;
      if (SCLK && !prev_sclk) begin
        rise_idx++;
        if (rise_idx == 1) t1 = cyc;
        if (rise_idx == 2) t2 = cyc;
      end
    end else begin
      if (!prev_ss) begin
        if (nl < 64) begin
          lows[nl]  = low_cnt;
          rises[nl] = rise_idx;
          pers[nl]  = t2 - t1;
        end
        nl++;
        gap_cnt = 0;
      end
      gap_cnt++;
    end
    if (sweep_done === 1'b1) n_done++;
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  // ----------------------------------------------------------------- helpers
  task automatic pulse_nxt();
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(posedge clk); #1;
      if (sweep_done === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  logic [15:0] exp_cmd [6];
  int fb;
  int mb;
  int db;
  logic hit;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    exp_cmd[0] = 16'h0000; exp_cmd[1] = 16'h0000;
    exp_cmd[2] = 16'h2000; exp_cmd[3] = 16'h2000;
    exp_cmd[4] = 16'h2800; exp_cmd[5] = 16'h2800;
    lft_val  = 12'h123;
    rght_val = 12'h456;
    batt_val = 12'hABC;
    rst = 1'b1;
    nxt = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", SS_n, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);
    check("rst_lft", lft_ld, 12'h000);
    check("rst_rght", rght_ld, 12'h000);
    check("rst_batt", batt, 12'h000);
    rst = 1'b0;

    // Single sweep with frame timing
    fb = nl; mb = m_n; db = n_done;
    pulse_nxt();
    check("s1_busy_rise", busy, 1);
    wait_done("s1_done_seen");
    check("s1_busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("s1_done_one_clk", sweep_done, 0);
    repeat (10) @(posedge clk);
    #1;
    check("s1_frames", nl - fb, 6);
    check("s1_model_frames", m_n - mb, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_cmd%0d", i), m_cmds[mb+i], exp_cmd[i]);
      check($sformatf("s1_low_ok%0d", i), (lows[fb+i] >= 512 && lows[fb+i] <= 528), 1);
      check($sformatf("s1_rises%0d", i), rises[fb+i], 16);
    end
    check("s1_sclk_period", pers[fb], 32);
    for (int i = 1; i < 6; i++) begin
      check($sformatf("s1_gap_ok%0d", i), (gaps[fb+i] >= 4), 1);
    end
    check("s1_done_count", n_done - db, 1);
    check("s1_lft", lft_ld, 12'h123);
    check("s1_rght", rght_ld, 12'h456);
    check("s1_batt", batt, 12'hABC);
    check("s1_busy_end", busy, 0);

    // Ignored triggers: mid-sweep and on the sweep_done clk
    fb = nl; mb = m_n; db = n_done;
    pulse_nxt();
    repeat (100) @(posedge clk);
    #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    check("s2_busy_hold", busy, 1);
    wait_done("s2_done_seen");
    nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("s2_frames", nl - fb, 6);
    check("s2_done_count", n_done - db, 1);
    check("s2_busy_idle", busy, 0);
    check("s2_ss_idle", SS_n, 1);

    // Reset in the 9th bit of ch4 frame B
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fb = nl;
    pulse_nxt();
    hit = 1'b0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      @(posedge clk); #1;
      if ((nl - fb == 3) && (SS_n === 1'b0) && (rise_idx == 8) && (SCLK === 1'b0)) hit = 1'b1;
    end
    check("s3_reach_bit9", hit, 1);
    check("s3_lft_before", lft_ld, 12'h123);
    check("s3_rght_before", rght_ld, 12'h000);
    rst = 1'b1;
    #1;
    check("s3_ss_n", SS_n, 1);
    check("s3_sclk", SCLK, 1);
    check("s3_rght", rght_ld, 12'h000);
    check("s3_lft", lft_ld, 12'h000);
    check("s3_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fb = nl; mb = m_n; db = n_done;
    pulse_nxt();
    wait_done("s3_done_seen");

    // Back-to-back sweep, nxt on the clk after sweep_done
    batt_val = 12'h7FF;
    up_nib   = 4'hF;
    @(posedge clk); #1;
    check("s3_frames", nl - fb, 6);
    check("s3_first_cmd", m_cmds[mb], 16'h0000);
    check("s3_lft_end", lft_ld, 12'h123);
    check("s3_rght_end", rght_ld, 12'h456);
    check("s3_batt_end", batt, 12'hABC);
    fb = nl; mb = m_n; db = n_done;
    nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    check("s4_busy_rise", busy, 1);
    wait_done("s4_done_seen");
    repeat (5) @(posedge clk);
    #1;
    check("s4_frames", nl - fb, 6);
    check("s4_done_count", n_done - db, 1);
    check("s4_lft", lft_ld, 12'h123);
    check("s4_rght", rght_ld, 12'h456);
    check("s4_batt", batt, 12'h7FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
